// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link blocks (piso serializer, sipo
// deserializer and later framing stages).
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a word of the given size.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a word over valid/ready and shifts it
// out one bit per enabled clock, streaming back-to-back words without a gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int             CNT_W   = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Handshake: a word transfers on the rising edge where load_valid and
    // load_ready are both high; load_ready never depends on load_valid.
    state_t           state, state_nx;
    logic [WIDTH-1:0] shift_reg, shift_nx;
    logic [CNT_W-1:0] bit_cnt, cnt_nx;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign busy        = (state == ST_SHIFT);
    assign frame_valid = busy;
    assign last_bit    = busy && (bit_cnt == CNT_LAST);
    assign load_ready  = (state == ST_IDLE) || (last_bit && shift_en);
    assign accept      = load_valid && load_ready;
    assign serial_out  = frame_valid ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : 1'b0;

    // Move the next bit toward whichever end drives serial_out.
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            bit_cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shift_nx = shift_reg;
        cnt_nx   = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_SHIFT;
                    shift_nx = parallel_in;
                    cnt_nx   = '0;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt != CNT_LAST) begin
                        shift_nx = shifted;
                        cnt_nx   = bit_cnt + 1'b1;
                    end else if (accept) begin
                        // Gap-free reload on the final bit of the current word.
                        shift_nx = parallel_in;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = ST_IDLE;
                        shift_nx = '0;
                        cnt_nx   = '0;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                shift_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: bit-level scoreboard plus a small
// left-shifting sipo model fed from serial_out as a loopback.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       lv4, se4, lv8, se8;
    logic [3:0] pin4;
    logic [7:0] pin8;
    logic       rdy4, so4, fv4, lb4, bz4;
    logic       rdy8, so8, fv8, lb8, bz8;
    logic [3:0] sipo_word;

    logic [0:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(rdy4),
        .parallel_in(pin4), .shift_en(se4), .serial_out(so4),
        .frame_valid(fv4), .last_bit(lb4), .busy(bz4)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(rdy8),
        .parallel_in(pin8), .shift_en(se8), .serial_out(so8),
        .frame_valid(fv8), .last_bit(lb8), .busy(bz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream sipo model: captures each valid, enabled bit MSB-first.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            sipo_word <= '0;
        else if (fv4 && se4)
            sipo_word <= {sipo_word[2:0], so4};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard,
    // then update the scoreboard for the upcoming edge.
    task automatic cyc(input bit sel, input logic lv, input logic [7:0] pin,
                       input logic se, input logic exp_ready, input string tag);
        logic       o_rdy, o_so, o_fv, o_lb, o_bz;
        logic       exp_frame, exp_last, exp_bit;
        int         w;
        if (!sel) begin
            lv4 = lv; pin4 = pin[3:0]; se4 = se;
        end else begin
            lv8 = lv; pin8 = pin; se8 = se;
        end
        #1;
        o_rdy = sel ? rdy8 : rdy4;
        o_so  = sel ? so8  : so4;
        o_fv  = sel ? fv8  : fv4;
        o_lb  = sel ? lb8  : lb4;
        o_bz  = sel ? bz8  : bz4;
        exp_frame = (exp_q.size() != 0);
        exp_last  = (exp_q.size() == 1);
        exp_bit   = exp_frame ? exp_q[0][0] : 1'b0;
        chk({tag, ".load_ready"},  8'(o_rdy), 8'(exp_ready));
        chk({tag, ".frame_valid"}, 8'(o_fv),  8'(exp_frame));
        chk({tag, ".busy"},        8'(o_bz),  8'(exp_frame));
        chk({tag, ".last_bit"},    8'(o_lb),  8'(exp_last));
        chk({tag, ".serial_out"},  8'(o_so),  8'(exp_bit));
        if (exp_frame && se)
            void'(exp_q.pop_front());
        if (lv && exp_ready) begin
            w = sel ? 8 : 4;
            for (int i = 0; i < w; i++)
                exp_q.push_back(sel ? pin[i] : pin[w-1-i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        lv4 = 1'b0; se4 = 1'b1; pin4 = '0;
        lv8 = 1'b0; se8 = 1'b1; pin8 = '0;
        #12;
        chk("reset.serial_out",  8'(so4),  8'h0);
        chk("reset.frame_valid", 8'(fv4),  8'h0);
        chk("reset.last_bit",    8'(lb4),  8'h0);
        chk("reset.busy",        8'(bz4),  8'h0);
        chk("reset.load_ready",  8'(rdy4), 8'h1);
        chk("reset.load_ready8", 8'(rdy8), 8'h1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single word 1011, MSB first
        cyc(0, 1, 8'h0B, 1, 1, "t1.acc");
        cyc(0, 0, 8'h00, 1, 0, "t1.b0");
        cyc(0, 0, 8'h00, 1, 0, "t1.b1");
        cyc(0, 0, 8'h00, 1, 0, "t1.b2");
        cyc(0, 0, 8'h00, 1, 1, "t1.b3");
        chk("t1.sipo", 8'(sipo_word), 8'h0B);
        cyc(0, 0, 8'h00, 1, 1, "t1.idle");

        // Back-to-back 1011 then 0110, second word held until accepted
        cyc(0, 1, 8'h0B, 1, 1, "t2.acc");
        cyc(0, 1, 8'h06, 1, 0, "t2.b0");
        cyc(0, 1, 8'h06, 1, 0, "t2.b1");
        cyc(0, 1, 8'h06, 1, 0, "t2.b2");
        cyc(0, 1, 8'h06, 1, 1, "t2.b3");
        chk("t2.sipo1", 8'(sipo_word), 8'h0B);
        cyc(0, 0, 8'h00, 1, 0, "t2.c0");
        cyc(0, 0, 8'h00, 1, 0, "t2.c1");
        cyc(0, 0, 8'h00, 1, 0, "t2.c2");
        cyc(0, 0, 8'h00, 1, 1, "t2.c3");
        chk("t2.sipo2", 8'(sipo_word), 8'h06);

        // Stall: 1100 with two frozen cycles on the first bit and one on the last
        cyc(0, 1, 8'h0C, 1, 1, "t3.acc");
        cyc(0, 0, 8'h00, 0, 0, "t3.s0");
        cyc(0, 0, 8'h00, 0, 0, "t3.s1");
        cyc(0, 0, 8'h00, 1, 0, "t3.b0");
        cyc(0, 0, 8'h00, 1, 0, "t3.b1");
        cyc(0, 0, 8'h00, 1, 0, "t3.b2");
        cyc(0, 1, 8'h05, 0, 0, "t3.s3");
        cyc(0, 0, 8'h00, 1, 1, "t3.b3");
        chk("t3.sipo", 8'(sipo_word), 8'h0C);

        // Protocol: 0101 offered mid-word, accepted only on the last-bit edge;
        // the first word is accepted with shift_en low
        cyc(0, 1, 8'h09, 0, 1, "t5.acc");
        cyc(0, 1, 8'h05, 1, 0, "t5.b0");
        cyc(0, 1, 8'h05, 1, 0, "t5.b1");
        cyc(0, 1, 8'h05, 1, 0, "t5.b2");
        cyc(0, 1, 8'h05, 1, 1, "t5.b3");
        chk("t5.sipo1", 8'(sipo_word), 8'h09);
        cyc(0, 0, 8'h00, 1, 0, "t5.c0");
        cyc(0, 0, 8'h00, 1, 0, "t5.c1");
        cyc(0, 0, 8'h00, 1, 0, "t5.c2");
        cyc(0, 0, 8'h00, 1, 1, "t5.c3");
        chk("t5.sipo2", 8'(sipo_word), 8'h05);

        // Asynchronous reset during bit 2 of 1111
        cyc(0, 1, 8'h0F, 1, 1, "t4.acc");
        cyc(0, 0, 8'h00, 1, 0, "t4.b0");
        cyc(0, 0, 8'h00, 1, 0, "t4.b1");
        #1;
        chk("t4.pre.frame_valid", 8'(fv4), 8'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("t4.rst.serial_out",  8'(so4),  8'h0);
        chk("t4.rst.frame_valid", 8'(fv4),  8'h0);
        chk("t4.rst.busy",        8'(bz4),  8'h0);
        chk("t4.rst.last_bit",    8'(lb4),  8'h0);
        chk("t4.rst.load_ready",  8'(rdy4), 8'h1);
        exp_q.delete();
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        cyc(0, 1, 8'h01, 1, 1, "t4.acc2");
        cyc(0, 0, 8'h00, 1, 0, "t4.c0");
        cyc(0, 0, 8'h00, 1, 0, "t4.c1");
        cyc(0, 0, 8'h00, 1, 0, "t4.c2");
        cyc(0, 0, 8'h00, 1, 1, "t4.c3");
        chk("t4.sipo", 8'(sipo_word), 8'h01);

        // LSB first, 8-bit word A5
        cyc(1, 1, 8'hA5, 1, 1, "t6.acc");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 8'h00, 1, (i == 7), $sformatf("t6.b%0d", i));
        cyc(1, 0, 8'h00, 1, 1, "t6.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
